// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit owning the HI/LO registers.
// Runs a fixed-latency mult/div on latched operands and commits to HI/LO on the final busy cycle.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0]    OP_MULT  = 3'd1;
  localparam logic [2:0]    OP_MULTU = 3'd2;
  localparam logic [2:0]    OP_DIV   = 3'd3;
  localparam logic [2:0]    OP_DIVU  = 3'd4;
  localparam logic [2:0]    OP_MTHI  = 3'd5;
  localparam logic [2:0]    OP_MTLO  = 3'd6;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [2:0]    r_op;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic               w_is_md;
  logic               w_accept;
  logic               w_mt_ok;
  logic               w_b_zero;
  logic               w_div_ovf;
  logic [31:0]        w_bs_safe;
  logic [31:0]        w_bu_safe;
  logic [63:0]        w_a_sx;
  logic [63:0]        w_b_sx;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;
  logic               w_res_vld;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;

  assign Busy = (r_cnt != CNT_ZERO);
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Issue qualification for new mult/div and for mthi/mtlo
  always_comb begin
    w_is_md  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
               (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    w_accept = Start && !Req && !Busy && w_is_md;
    w_mt_ok  = !Start && !Req && !Busy;
  end

  // Arithmetic on latched operands; selected result for the commit edge
  always_comb begin
    w_b_zero  = (r_b == 32'd0);
    // INT_MIN / -1 is steered to a divide-by-one, which yields exactly the wrapped result
    w_div_ovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    w_bs_safe = (w_b_zero || w_div_ovf) ? 32'd1 : r_b;
    w_bu_safe = w_b_zero ? 32'd1 : r_b;
    w_a_sx    = {{32{r_a[31]}}, r_a};
    w_b_sx    = {{32{r_b[31]}}, r_b};
    w_prod_s  = w_a_sx * w_b_sx;
    w_prod_u  = {32'd0, r_a} * {32'd0, r_b};
    w_quo_s   = $signed(r_a) / $signed(w_bs_safe);
    w_rem_s   = $signed(r_a) % $signed(w_bs_safe);
    w_quo_u   = r_a / w_bu_safe;
    w_rem_u   = r_a % w_bu_safe;
    w_res_vld = 1'b0;
    w_res_hi  = r_hi;
    w_res_lo  = r_lo;
    case (r_op)
      OP_MULT: begin
        w_res_vld = 1'b1;
        w_res_hi  = w_prod_s[63:32];
        w_res_lo  = w_prod_s[31:0];
      end
      OP_MULTU: begin
        w_res_vld = 1'b1;
        w_res_hi  = w_prod_u[63:32];
        w_res_lo  = w_prod_u[31:0];
      end
      OP_DIV: begin
        w_res_vld = !w_b_zero;
        w_res_hi  = w_rem_s;
        w_res_lo  = w_quo_s;
      end
      OP_DIVU: begin
        w_res_vld = !w_b_zero;
        w_res_hi  = w_rem_u;
        w_res_lo  = w_quo_u;
      end
      default: begin
        w_res_vld = 1'b0;
        w_res_hi  = r_hi;
        w_res_lo  = r_lo;
      end
    endcase
  end

  // Latency counter, operand latch and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= CNT_ZERO;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_op  <= 3'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (r_cnt > CNT_ONE) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else if (r_cnt == CNT_ONE) begin
      r_cnt <= CNT_ZERO;
      if (w_res_vld) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_op  <= MDUOp;
      r_cnt <= ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU)) ? CNT_MULT : CNT_DIV;
    end else if (w_mt_ok && (MDUOp == OP_MTHI)) begin
      r_hi <= A;
    end else if (w_mt_ok && (MDUOp == OP_MTLO)) begin
      r_lo <= A;
    end
  end

endmodule
